// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU program sequencer.
package alu_seq_pkg;

   localparam int OPC_W = 3;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_SHL = 3'b010,
      OP_SHR = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_NOT = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_EXEC  = 2'b10,
      ST_HALT  = 2'b11
   } state_t;

   // Instruction word width: opcode followed by operands A and B.
   function automatic int instr_w(input int width);
      return OPC_W + 2 * width;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU: eight operations, result plus carry.
module alu_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;
   logic           w_shift_big;

   // Extra top bit captures carry-out; for subtraction it is the no-borrow flag.
   assign w_sum       = {1'b0, a} + {1'b0, b};
   assign w_diff      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign w_shift_big = ({1'b0, b} >= (WIDTH+1)'(WIDTH));

   // Operation select; shifts by WIDTH or more saturate to zero.
   always_comb begin
      result = {WIDTH{1'b0}};
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = w_sum[WIDTH-1:0];
            carry  = w_sum[WIDTH];
         end
         OP_SUB: begin
            result = w_diff[WIDTH-1:0];
            carry  = w_diff[WIDTH];
         end
         OP_SHL: result = w_shift_big ? {WIDTH{1'b0}} : (a << b);
         OP_SHR: result = w_shift_big ? {WIDTH{1'b0}} : (a >> b);
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         default: begin
            result = {WIDTH{1'b0}};
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_program_sequencer.sv
// Fetch/execute sequencer: reads instructions from an external ROM and
// registers ALU results and flags, with start/stall/done control.
module alu_program_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int ADDR_W   = 6,
   parameter int PROG_LEN = 64,
   parameter int WRAP     = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stall,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [OPC_W+2*WIDTH-1:0] rom_data,
   output logic [WIDTH-1:0]         result,
   output logic                     result_valid,
   output logic                     flag_zero,
   output logic                     flag_carry,
   output logic                     busy,
   output logic                     done
);

   localparam int                IW      = instr_w(WIDTH);
   localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PROG_LEN - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [IW-1:0]     r_ir;
   logic [WIDTH-1:0]  r_result;
   logic              r_result_valid;
   logic              r_flag_zero;
   logic              r_flag_carry;
   logic              r_busy;
   logic              r_done_pulse;
   logic              r_done_hold;

   op_t               w_op;
   logic [WIDTH-1:0]  w_a;
   logic [WIDTH-1:0]  w_b;
   logic [WIDTH-1:0]  w_alu_result;
   logic              w_alu_carry;

   assign w_op = op_t'(r_ir[IW-1 -: OPC_W]);
   assign w_a  = r_ir[2*WIDTH-1 -: WIDTH];
   assign w_b  = r_ir[WIDTH-1:0];

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op     (w_op),
      .a      (w_a),
      .b      (w_b),
      .result (w_alu_result),
      .carry  (w_alu_carry)
   );

   // Pulses stay pending while stalled and appear on the first unstalled cycle.
   assign rom_addr     = r_pc;
   assign result       = r_result;
   assign result_valid = r_result_valid & ~stall;
   assign flag_zero    = r_flag_zero;
   assign flag_carry   = r_flag_carry;
   assign busy         = r_busy;
   assign done         = r_done_hold | (r_done_pulse & ~stall);

   // Sequencer FSM with all datapath registers; stall freezes everything.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_pc           <= {ADDR_W{1'b0}};
         r_ir           <= {IW{1'b0}};
         r_result       <= {WIDTH{1'b0}};
         r_result_valid <= 1'b0;
         r_flag_zero    <= 1'b0;
         r_flag_carry   <= 1'b0;
         r_busy         <= 1'b0;
         r_done_pulse   <= 1'b0;
         r_done_hold    <= 1'b0;
      end else if (stall) begin
         r_state <= r_state;
      end else begin
         r_result_valid <= 1'b0;
         r_done_pulse   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_pc    <= {ADDR_W{1'b0}};
                  r_busy  <= 1'b1;
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               r_ir    <= rom_data;
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               r_result       <= w_alu_result;
               r_flag_carry   <= w_alu_carry;
               r_flag_zero    <= (w_alu_result == {WIDTH{1'b0}});
               r_result_valid <= 1'b1;
               if (r_pc != PC_LAST) begin
                  r_pc    <= r_pc + ADDR_W'(1);
                  r_state <= ST_FETCH;
               end else if (WRAP != 0) begin
                  r_pc         <= {ADDR_W{1'b0}};
                  r_done_pulse <= 1'b1;
                  r_state      <= ST_FETCH;
               end else begin
                  r_done_hold <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_HALT;
               end
            end
            ST_HALT: begin
               if (start) begin
                  r_done_hold <= 1'b0;
                  r_pc        <= {ADDR_W{1'b0}};
                  r_busy      <= 1'b1;
                  r_state     <= ST_FETCH;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_program_sequencer.md
Name: alu_program_sequencer

Overview:
- Parametrised successor to the fixed 8-bit counter/ROM/splitter/ALU chain.
- Fetches instruction words from an external combinational program ROM and executes them on a WIDTH-bit ALU.
- Registers each result together with zero and carry flags.
- Adds a start/stall/done control handshake and selectable wrap or halt at end of program.

Parameters:
- WIDTH, 8, ALU operand and result width (>= 2).
- ADDR_W, 6, program counter / ROM address width.
- PROG_LEN, 64, number of valid instructions; range 1 to 2**ADDR_W.
- WRAP, 1, 1: restart at address 0 after last instruction; 0: halt.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, begin execution from address 0; sampled in IDLE and HALT only.
- stall, input, 1, freeze all state while high.
- rom_addr, output, ADDR_W, program ROM address.
- rom_data, input, 3+2*WIDTH, instruction word: [2*WIDTH+2:2*WIDTH] opcode, next WIDTH bits operand A, low WIDTH bits operand B.
- result, output, WIDTH, last executed result.
- result_valid, output, 1, one-cycle pulse when result/flags update.
- flag_zero, output, 1, result == 0.
- flag_carry, output, 1, carry / no-borrow of last op.
- busy, output, 1, high in FETCH or EXEC.
- done, output, 1, end-of-program indication.

Behaviour:
- Reset (asynchronous): state=IDLE, pc=0, instruction register=0. Outputs result=0, result_valid=0, flag_zero=0, flag_carry=0, busy=0, done=0. Reset mid-operation discards the in-flight instruction.
- States and transitions:
  - IDLE: on start → FETCH with pc=0.
  - FETCH: rom_addr=pc; rom_data is latched into the instruction register at the clock edge; next state EXEC.
  - EXEC: ALU evaluates the latched instruction; result/flags are registered at the edge; result_valid=1 in the following cycle.
  - From EXEC, if pc != PROG_LEN-1: pc+1 → FETCH.
  - From EXEC, if pc == PROG_LEN-1 and WRAP=1: pc=0, done pulses 1 cycle, → FETCH.
  - From EXEC, if pc == PROG_LEN-1 and WRAP=0: → HALT, done=1 held.
  - HALT: outputs hold; on start, done clears, pc=0, → FETCH.
- Throughput: one instruction per 2 cycles. Latency from start sampled to first result_valid is 3 cycles.
- rom_addr always drives pc, including in IDLE and HALT.
- stall=1: state, pc, instruction register, result and flags hold. result_valid and the done pulse are suppressed while stalled and fire on the first unstalled cycle after the EXEC edge. stall has priority over start.
- start while busy: ignored.
- Opcodes (all arithmetic modulo 2**WIDTH):
  - 000 ADD: A+B; carry=carry-out.
  - 001 SUB: A+~B+1 (two's complement); carry=1 iff A>=B unsigned.
  - 010 SHL: A << B; shift amount >= WIDTH gives 0; carry=0.
  - 011 SHR: logical A >> B; same saturation rule; carry=0.
  - 100 AND, 101 OR, 110 XOR: bitwise; carry=0.
  - 111 NOT: ~A, B ignored; carry=0.
- flag_zero recomputed on every executed instruction.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode enum op_t (ADD..NOT, 3 bits);
  - state enum state_t (IDLE, FETCH, EXEC, HALT);
  - constant OPC_W=3;
  - function instr_w(width) = 3+2*width.
- Sub-module alu_core: purely combinational, WIDTH-parametrised; inputs op, A, B; outputs result and carry. The sequencer owns all registers and the FSM.

Test Plan:
- WIDTH=8, PROG_LEN=1, WRAP=0, rom ADD 0xF0,0x20, start pulse → result_valid 3 cycles later, result=0x10, carry=1, zero=0, then HALT with done=1 held.
- SUB 0x05,0x07 → result=0xFE, carry=0; SUB 0x07,0x05 → 0x02, carry=1; SUB 0x09,0x09 → 0x00, zero=1, carry=1.
- SHL 0x01,0x09 → 0x00, zero=1; SHR 0x80,0x07 → 0x01; NOT 0x5A → 0xA5; XOR 0xFF,0x0F → 0xF0.
- PROG_LEN=4, WRAP=1, run 10 instructions → rom_addr sequence 0,1,2,3,0,1,…; done pulses exactly once per wrap; busy stays 1.
- Assert stall for 5 cycles during EXEC → pc, result and flags unchanged; result_valid fires once, on the first cycle after stall drops.
- Assert reset during EXEC of address 2 → all outputs 0, state IDLE; start re-executes from rom_addr=0. A start pulse while busy leaves the pc sequence unchanged.
